// File: rtl/mult_div_unit.sv
// E-stage multiply/divide controller owning the architectural HI/LO registers.
// Results are computed at the start edge and committed after a fixed busy window.
module mult_div_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        StartE,
   input  logic [2:0]  MDOpE,
   input  logic [31:0] RD1E,
   input  logic [31:0] RD2E,
   output logic        BusyE,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic [2:0] OpNone  = 3'b000;
   localparam logic [2:0] OpMult  = 3'b001;
   localparam logic [2:0] OpMultu = 3'b010;
   localparam logic [2:0] OpDiv   = 3'b011;
   localparam logic [2:0] OpDivu  = 3'b100;
   localparam logic [2:0] OpMthi  = 3'b101;
   localparam logic [2:0] OpMtlo  = 3'b110;

   localparam logic [3:0] MulLoad = 4'(MULT_CYCLES);
   localparam logic [3:0] DivLoad = 4'(DIV_CYCLES);

   typedef enum logic [1:0] {
      StIdle,
      StMul,
      StDiv
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] pend_hi_q, pend_hi_d;
   logic [31:0] pend_lo_q, pend_lo_d;
   logic        pend_valid_q, pend_valid_d;

   // Product datapath: sign-extend for MULT, zero-extend for MULTU.
   logic        mul_signed;
   logic [63:0] mul_a, mul_b, mul_prod;

   always_comb begin
      mul_signed = (MDOpE == OpMult);
      mul_a      = {{32{mul_signed & RD1E[31]}}, RD1E};
      mul_b      = {{32{mul_signed & RD2E[31]}}, RD2E};
      mul_prod   = mul_a * mul_b;
   end

   // Divide on magnitudes, then restore signs; quotient truncates toward zero and the
   // remainder follows the dividend. 0x80000000 / -1 wraps naturally to 0x80000000.
   logic        div_signed, div_zero, neg_a, neg_b;
   logic [31:0] mag_a, mag_b, mag_b_safe, q_mag, r_mag, div_q, div_r;

   always_comb begin
      div_signed = (MDOpE == OpDiv);
      div_zero   = (RD2E == 32'd0);
      neg_a      = div_signed & RD1E[31];
      neg_b      = div_signed & RD2E[31];
      mag_a      = neg_a ? (~RD1E + 32'd1) : RD1E;
      mag_b      = neg_b ? (~RD2E + 32'd1) : RD2E;
      mag_b_safe = div_zero ? 32'd1 : mag_b;
      q_mag      = mag_a / mag_b_safe;
      r_mag      = mag_a % mag_b_safe;
      div_q      = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
      div_r      = neg_a ? (~r_mag + 32'd1) : r_mag;
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      pend_hi_d    = pend_hi_q;
      pend_lo_d    = pend_lo_q;
      pend_valid_d = pend_valid_q;

      unique case (state_q)
         StIdle: begin
            if (StartE) begin
               case (MDOpE)
                  OpMult, OpMultu: begin
                     pend_hi_d    = mul_prod[63:32];
                     pend_lo_d    = mul_prod[31:0];
                     pend_valid_d = 1'b1;
                     cnt_d        = MulLoad;
                     state_d      = StMul;
                  end
                  OpDiv, OpDivu: begin
                     pend_hi_d    = div_r;
                     pend_lo_d    = div_q;
                     // Divide by zero still runs the window but leaves HI/LO alone.
                     pend_valid_d = ~div_zero;
                     cnt_d        = DivLoad;
                     state_d      = StDiv;
                  end
                  OpMthi:  hi_d = RD1E;
                  OpMtlo:  lo_d = RD1E;
                  OpNone:  ;
                  default: ;
               endcase
            end
         end
         StMul, StDiv: begin
            if (cnt_q <= 4'd1) begin
               if (pend_valid_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
               pend_valid_d = 1'b0;
               cnt_d        = 4'd0;
               state_d      = StIdle;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         cnt_q        <= 4'd0;
         hi_q         <= 32'd0;
         lo_q         <= 32'd0;
         pend_hi_q    <= 32'd0;
         pend_lo_q    <= 32'd0;
         pend_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         pend_hi_q    <= pend_hi_d;
         pend_lo_q    <= pend_lo_d;
         pend_valid_q <= pend_valid_d;
      end
   end

   assign BusyE = (state_q != StIdle);
   assign HI    = hi_q;
   assign LO    = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with default cycle counts (5 / 10).
module tb_mult_div_unit;

   logic        clk;
   logic        reset;
   logic        StartE;
   logic [2:0]  MDOpE;
   logic [31:0] RD1E;
   logic [31:0] RD2E;
   logic        BusyE;
   logic [31:0] HI;
   logic [31:0] LO;

   int errors;
   int checks;

   mult_div_unit #(
      .MULT_CYCLES(5),
      .DIV_CYCLES (10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .StartE(StartE),
      .MDOpE (MDOpE),
      .RD1E  (RD1E),
      .RD2E  (RD2E),
      .BusyE (BusyE),
      .HI    (HI),
      .LO    (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one request at a negedge; returns just after the start edge.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      StartE = 1'b1;
      MDOpE  = op;
      RD1E   = a;
      RD2E   = b;
      @(posedge clk);
      #1;
      StartE = 1'b0;
      MDOpE  = 3'b000;
   endtask

   // Count busy cycles from the next negedge; ends at the negedge of the first idle cycle.
   task automatic count_busy(output int n);
      n = 0;
      @(negedge clk);
      while (BusyE === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset  = 1'b1;
      StartE = 1'b0;
      MDOpE  = 3'b000;
      RD1E   = 32'd0;
      RD2E   = 32'd0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if (BusyE !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
         errors++;
         $display("FAIL reset: busy=%b hi=%h lo=%h, want 0/0/0", BusyE, HI, LO);
      end
   endtask

   task automatic test_mult;
      int n;
      logic bad;
      issue(3'b001, 32'hFFFF_FFFE, 32'd3);
      n   = 0;
      bad = 1'b0;
      @(negedge clk);
      while (BusyE === 1'b1 && n < 40) begin
         n++;
         if (HI !== 32'd0 || LO !== 32'd0) bad = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (n != 5) begin
         errors++;
         $display("FAIL mult_busy: cycles=%0d, want 5", n);
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL mult_hold: HI/LO changed while busy");
      end
      checks++;
      if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
         errors++;
         $display("FAIL mult_result: hi=%h lo=%h, want ffffffff/fffffffa", HI, LO);
      end
   endtask

   task automatic test_multu;
      int n;
      issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      count_busy(n);
      checks++;
      if (n != 5) begin
         errors++;
         $display("FAIL multu_busy: cycles=%0d, want 5", n);
      end
      checks++;
      if (HI !== 32'hFFFF_FFFE || LO !== 32'h0000_0001) begin
         errors++;
         $display("FAIL multu_result: hi=%h lo=%h, want fffffffe/00000001", HI, LO);
      end
   endtask

   // DIVU is issued in the first idle cycle after DIV completes (back-to-back).
   task automatic test_div_back_to_back;
      int n;
      issue(3'b011, 32'hFFFF_FFF9, 32'd2);
      count_busy(n);
      checks++;
      if (n != 10) begin
         errors++;
         $display("FAIL div_busy: cycles=%0d, want 10", n);
      end
      checks++;
      if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
         errors++;
         $display("FAIL div_result: hi=%h lo=%h, want ffffffff/fffffffd", HI, LO);
      end
      StartE = 1'b1;
      MDOpE  = 3'b100;
      RD1E   = 32'd7;
      RD2E   = 32'd2;
      @(posedge clk);
      #1;
      StartE = 1'b0;
      MDOpE  = 3'b000;
      RD1E   = 32'hDEAD_BEEF;
      RD2E   = 32'd0;
      count_busy(n);
      checks++;
      if (n != 10) begin
         errors++;
         $display("FAIL divu_b2b_busy: cycles=%0d, want 10", n);
      end
      checks++;
      if (HI !== 32'd1 || LO !== 32'd3) begin
         errors++;
         $display("FAIL divu_result: hi=%h lo=%h, want 00000001/00000003", HI, LO);
      end
   endtask

   task automatic test_mthi_mtlo;
      @(negedge clk);
      StartE = 1'b1;
      MDOpE  = 3'b101;
      RD1E   = 32'h1234_5678;
      @(posedge clk);
      #1;
      MDOpE = 3'b110;
      RD1E  = 32'h9ABC_DEF0;
      @(negedge clk);
      checks++;
      if (HI !== 32'h1234_5678 || BusyE !== 1'b0 || LO !== 32'd3) begin
         errors++;
         $display("FAIL mthi: hi=%h lo=%h busy=%b, want 12345678/00000003/0", HI, LO, BusyE);
      end
      @(posedge clk);
      #1;
      StartE = 1'b0;
      MDOpE  = 3'b000;
      @(negedge clk);
      checks++;
      if (LO !== 32'h9ABC_DEF0 || HI !== 32'h1234_5678 || BusyE !== 1'b0) begin
         errors++;
         $display("FAIL mtlo: hi=%h lo=%h busy=%b, want 12345678/9abcdef0/0", HI, LO, BusyE);
      end
   endtask

   task automatic test_ignore_busy;
      int n;
      issue(3'b001, 32'd6, 32'd7);
      issue(3'b110, 32'd1, 32'd0);
      count_busy(n);
      checks++;
      if (n != 4) begin
         errors++;
         $display("FAIL ignore_busy_len: remaining=%0d, want 4", n);
      end
      checks++;
      if (HI !== 32'd0 || LO !== 32'd42) begin
         errors++;
         $display("FAIL ignore_busy_result: hi=%h lo=%h, want 00000000/0000002a", HI, LO);
      end
   endtask

   task automatic test_div_zero_overflow;
      int n;
      issue(3'b101, 32'h0000_00AA, 32'd0);
      issue(3'b110, 32'h0000_00BB, 32'd0);
      issue(3'b011, 32'd5, 32'd0);
      count_busy(n);
      checks++;
      if (n != 10) begin
         errors++;
         $display("FAIL divzero_busy: cycles=%0d, want 10", n);
      end
      checks++;
      if (HI !== 32'h0000_00AA || LO !== 32'h0000_00BB) begin
         errors++;
         $display("FAIL divzero_result: hi=%h lo=%h, want 000000aa/000000bb", HI, LO);
      end
      issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
      count_busy(n);
      checks++;
      if (HI !== 32'd0 || LO !== 32'h8000_0000) begin
         errors++;
         $display("FAIL div_overflow: hi=%h lo=%h, want 00000000/80000000", HI, LO);
      end
   endtask

   task automatic test_reset_mid_and_reserved;
      issue(3'b011, 32'd100, 32'd7);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if (BusyE !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid: busy=%b hi=%h lo=%h, want 0/0/0", BusyE, HI, LO);
      end
      repeat (15) @(negedge clk);
      checks++;
      if (BusyE !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
         errors++;
         $display("FAIL reset_no_commit: busy=%b hi=%h lo=%h, want 0/0/0", BusyE, HI, LO);
      end
      issue(3'b101, 32'h0000_0055, 32'd0);
      issue(3'b111, 32'h0000_0077, 32'd3);
      issue(3'b000, 32'h0000_0099, 32'd3);
      @(negedge clk);
      checks++;
      if (BusyE !== 1'b0 || HI !== 32'h0000_0055 || LO !== 32'd0) begin
         errors++;
         $display("FAIL reserved_op: busy=%b hi=%h lo=%h, want 0/00000055/0", BusyE, HI, LO);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_mult();
      test_multu();
      test_div_back_to_back();
      test_mthi_mtlo();
      test_ignore_busy();
      test_div_zero_overflow();
      test_reset_mid_and_reserved();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Execute-stage multiply/divide controller that owns the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E, sequences a fixed-latency busy window, and commits results to HI/LO at completion.
- Exports Busy so hazard logic can stall D-stage MFHI/MFLO and multiply/divide instructions.
- Sits beside the E-stage ALU and is fed by the same forwarded operands RD1E/RD2E.

Parameters:
- MULT_CYCLES, 5, number of cycles Busy stays high for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10, number of cycles Busy stays high for DIV/DIVU (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- StartE  input  1  single-cycle request from the E stage; qualified by MDOpE.
- MDOpE  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved.
- RD1E  input  32  rs operand (multiplicand/dividend; MTHI/MTLO source).
- RD2E  input  32  rt operand (multiplier/divisor).
- BusyE  output  1  high while a multiply/divide is in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Reset (sync, active-high): HI=0, LO=0, BusyE=0, state=IDLE, counter=0, pending results cleared. Reset mid-operation aborts the operation, and HI/LO are never written by it.
- States:
  - IDLE: BusyE=0.
  - MUL: BusyE=1.
  - DIV: BusyE=1.
- IDLE + StartE + MULT/MULTU at edge t:
  - Latch RD1E/RD2E.
  - Compute the 64-bit product into pending registers (signed for MULT, unsigned for MULTU).
  - Load counter=MULT_CYCLES and go to MUL.
- IDLE + StartE + DIV/DIVU at edge t:
  - Compute the quotient into pendingLO and the remainder into pendingHI.
  - Load counter=DIV_CYCLES and go to DIV.
- MUL/DIV:
  - Counter decrements each cycle.
  - BusyE is high for exactly N cycles (t+1 .. t+N, N = MULT_CYCLES or DIV_CYCLES).
  - At the edge ending cycle t+N, commit pending HI/LO and return to IDLE.
  - New HI/LO are visible in the first cycle BusyE is low.
- Back-to-back: StartE may be asserted in the first IDLE cycle after completion. That operation starts normally and BusyE goes high again on the next cycle.
- MTHI/MTLO in IDLE with StartE: write RD1E to HI (resp. LO) at the same edge, with no busy window. Visible next cycle.
- StartE while BusyE=1 (any op, including MTHI/MTLO): ignored. The in-flight operation and HI/LO are unaffected. Hazard logic must prevent this case; the unit tolerates it anyway.
- StartE with MDOpE=000 or 111: ignored, no state change.
- Signed divide rules:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0x00000000 (no trap).
- Divide by zero (DIV or DIVU with RD2E=0): the full DIV_CYCLES busy window still runs, and HI/LO keep their prior values at completion.
- Operands are captured at the start edge. Changes on RD1E/RD2E during Busy have no effect.
- HI/LO are driven directly from registers. There is no combinational path from inputs to HI/LO/BusyE.

Test Plan:
- Reset, then MULT RD1E=0xFFFFFFFE(-2), RD2E=3 -> BusyE high exactly 5 cycles; after that HI=0xFFFFFFFF, LO=0xFFFFFFFA. HI/LO unchanged (0/0) while busy.
- MULTU RD1E=0xFFFFFFFF, RD2E=0xFFFFFFFF -> after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV RD1E=0xFFFFFFF9(-7), RD2E=2 -> BusyE high 10 cycles; then LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1). Then DIVU 7/2 -> LO=3, HI=1.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles -> HI/LO update one cycle after each, BusyE stays 0. Issue MTLO 0x1 during a MULT busy window -> ignored, and the MULT result commits.
- DIV by zero after HI=0xAA, LO=0xBB -> 10 busy cycles, then HI=0xAA, LO=0xBB. Then 0x80000000 DIV 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start DIV, assert reset in busy cycle 4 -> next cycle BusyE=0, HI=LO=0, and no later commit occurs. Then StartE with MDOpE=111 -> no change.
